shape_sequencer: RTL and testbench
==================================

# shape_sequencer

Command-side controller for the subshape splitter path. Accepts one shape command at a time (line, circle, triangle, square) with its vertex data and color. Breaks it into an ordered stream of primitive segments over a valid/ready handshake toward the splitter/rasterizer. Owns all sequencing so downstream logic only ever sees single two-point primitives.

## Interface
- No parameters. Point format fixed: 19 bits = {x[9:0], y[8:0]}.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_sel  in  4  0=line, 1=circle, 2=triangle, 3=square, 4–15 unsupported
- cmd_data  in  76  P0=[75:57], P1=[56:38], P2=[37:19], P3=[18:0]
- cmd_color  in  16  RGB565 color
- seg_valid  out  1  segment present
- seg_ready  in  1  downstream consumed segment (read strobe)
- seg_data  out  38  {start point [37:19], end point [18:0]}; circle: {center, radius point}
- seg_color  out  16  latched cmd_color
- seg_kind  out  1  0=line segment, 1=circle primitive
- seg_last  out  1  final segment of current shape
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on acceptance of unsupported cmd_sel
- shapes_done  out  16  count of completed shapes, wraps 0xFFFF→0

## Operation
- States: IDLE, LINE, CIRC, TRI1, TRI2, TRI3, SQ1, SQ2, SQ3, SQ4.
- cmd_ready = 1 only in IDLE and rst low. Accept = cmd_valid & cmd_ready; latch cmd_data, cmd_color, go to LINE/CIRC/TRI1/SQ1 by cmd_sel.
- Unsupported sel: accepted, err=1 next cycle, stay IDLE, no segments, shapes_done unchanged.
- Segments emitted, with latched (x0,y0)=P0, (x1,y1)=P1, P2:
  - LINE: P0→P1, last.
  - CIRC: {P0,P1}, seg_kind=1, last.
  - TRI1 P0→P1; TRI2 P1→P2; TRI3 P2→P0, last.
  - SQ (P0, P1 opposite corners): SQ1 (x0,y0)→(x1,y0); SQ2 (x1,y0)→(x1,y1); SQ3 (x1,y1)→(x0,y1); SQ4 (x0,y1)→(x0,y0), last.
- P3 ignored for all current shapes.
- Advance only on seg_valid & seg_ready; on last handshake go IDLE and increment shapes_done.
- Degenerate geometry (zero-length edges, collinear triangle) is emitted unchanged; no filtering.

## Timing
- Reset (edge with rst=1): state IDLE; seg_valid, seg_data, seg_color, seg_kind, seg_last, busy, err, shapes_done = 0; cmd_ready=0 while rst high, 1 in first cycle after.
- All seg_* outputs registered. Command accepted at edge N → seg_valid=1 with first segment from cycle N+1.
- seg_data/seg_color/seg_kind/seg_last held stable while seg_valid & !seg_ready; seg_valid never drops without handshake.
- Next segment valid in cycle after handshake; back-to-back with seg_ready held 1: line 1 cycle, triangle 3, square 4.
- After last handshake, IDLE for ≥1 cycle: cmd_ready=1 in cycle following last handshake; no command accepted in same cycle as last handshake.
- cmd_* ignored while not IDLE (no buffering).
- rst mid-shape: shape abandoned, seg_valid=0 next cycle, shapes_done cleared, no partial completion counted.
- err asserted exactly one cycle, cycle after acceptance.

## Test plan
- Reset then idle: rst 2 cycles → all outputs 0, cmd_ready=1 cycle after deassert, busy=0.
- Line: sel=0, P0=(10,20), P1=(100,200), seg_ready=1 → one segment {(10,20),(100,200)}, seg_last=1, shapes_done=1, cmd_ready back 1 cycle later.
- Square with backpressure: sel=3, P0=(5,5), P1=(50,40), seg_ready low 3 cycles per segment → segments (5,5)→(50,5), (50,5)→(50,40), (50,40)→(5,40), (5,40)→(5,5), data stable while stalled, last only on 4th.
- Triangle + circle back-to-back: tri P0=(0,0),P1=(639,0),P2=(320,479), then circle center (320,240) radius (50,0) → 3 line segments then one seg_kind=1; shapes_done=2.
- Unsupported sel=7 → accepted, err one-cycle pulse, seg_valid stays 0, shapes_done unchanged.
- Reset during SQ2 with seg_ready=0 → seg_valid=0 after reset edge, shapes_done=0, subsequent line command processed normally.

Source files
------------

// File: rtl/shape_sequencer.sv
// shape_sequencer: breaks line/circle/triangle/square commands into a
// registered valid/ready stream of two-point primitives.
module shape_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_sel,
    input  logic [75:0] cmd_data,
    input  logic [15:0] cmd_color,
    output logic        seg_valid,
    input  logic        seg_ready,
    output logic [37:0] seg_data,
    output logic [15:0] seg_color,
    output logic        seg_kind,
    output logic        seg_last,
    output logic        busy,
    output logic        err,
    output logic [15:0] shapes_done
);
    typedef enum logic [3:0] {
        IDLE, LINE, CIRC, TRI1, TRI2, TRI3, SQ1, SQ2, SQ3, SQ4
    } state_t;

    state_t state, state_n;
    logic [18:0] p0, p1, p2, p0_n, p1_n, p2_n;
    logic [37:0] data_n;
    logic kind_n, last_n, accept, hs, done;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept = cmd_valid && cmd_ready;
    assign hs = seg_valid && seg_ready;
    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            IDLE: if (accept)
                state_n = cmd_sel == 4'd0 ? LINE :
                          cmd_sel == 4'd1 ? CIRC :
                          cmd_sel == 4'd2 ? TRI1 :
                          cmd_sel == 4'd3 ? SQ1 : IDLE;
            TRI1: if (hs) state_n = TRI2;
            TRI2: if (hs) state_n = TRI3;
            SQ1:  if (hs) state_n = SQ2;
            SQ2:  if (hs) state_n = SQ3;
            SQ3:  if (hs) state_n = SQ4;
            default: if (hs) begin
                state_n = IDLE;
                done = 1'b1;
            end
        endcase
    end

    // Segment registers are loaded from the next state so data is valid the
    // cycle the state is entered, and naturally held while stalled.
    always_comb begin
        p0_n = accept ? cmd_data[75:57] : p0;
        p1_n = accept ? cmd_data[56:38] : p1;
        p2_n = accept ? cmd_data[37:19] : p2;
        data_n = '0;
        kind_n = 1'b0;
        last_n = 1'b0;
        case (state_n)
            LINE: begin data_n = {p0_n, p1_n}; last_n = 1'b1; end
            CIRC: begin data_n = {p0_n, p1_n}; last_n = 1'b1; kind_n = 1'b1; end
            TRI1: data_n = {p0_n, p1_n};
            TRI2: data_n = {p1_n, p2_n};
            TRI3: begin data_n = {p2_n, p0_n}; last_n = 1'b1; end
            SQ1:  data_n = {p0_n[18:9], p0_n[8:0], p1_n[18:9], p0_n[8:0]};
            SQ2:  data_n = {p1_n[18:9], p0_n[8:0], p1_n[18:9], p1_n[8:0]};
            SQ3:  data_n = {p1_n[18:9], p1_n[8:0], p0_n[18:9], p1_n[8:0]};
            SQ4:  begin data_n = {p0_n[18:9], p1_n[8:0], p0_n[18:9], p0_n[8:0]}; last_n = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
            seg_valid <= 1'b0;
            seg_data <= '0;
            seg_color <= '0;
            seg_kind <= 1'b0;
            seg_last <= 1'b0;
            err <= 1'b0;
            shapes_done <= '0;
        end else begin
            state <= state_n;
            p0 <= p0_n;
            p1 <= p1_n;
            p2 <= p2_n;
            seg_valid <= (state_n != IDLE);
            seg_data <= data_n;
            seg_kind <= kind_n;
            seg_last <= last_n;
            if (accept) seg_color <= cmd_color;
            err <= accept && (cmd_sel > 4'd3);
            if (done) shapes_done <= shapes_done + 16'd1;
        end
    end
endmodule

// File: tb/tb_shape_sequencer.sv
// tb_shape_sequencer: directed checks of shape_sequencer segment streams,
// backpressure, errors and reset behaviour.
module tb_shape_sequencer;
    logic clk = 0, rst = 1, cmd_valid = 0, seg_ready = 0;
    logic [3:0] cmd_sel = 0;
    logic [75:0] cmd_data = 0;
    logic [15:0] cmd_color = 0;
    logic cmd_ready, seg_valid, seg_kind, seg_last, busy, err;
    logic [37:0] seg_data;
    logic [15:0] seg_color, shapes_done;
    int total = 0, bad = 0;
    logic [37:0] sq [4];

    shape_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_data(cmd_data), .cmd_color(cmd_color),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_data(seg_data),
        .seg_color(seg_color), .seg_kind(seg_kind), .seg_last(seg_last),
        .busy(busy), .err(err), .shapes_done(shapes_done)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pt(input int x, input int y);
        logic [9:0] xx;
        logic [8:0] yy;
        xx = x[9:0];
        yy = y[8:0];
        return {xx, yy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cmd(input logic [3:0] s, input logic [18:0] a, input logic [18:0] b,
                       input logic [18:0] c, input logic [15:0] col);
        cmd_valid = 1;
        cmd_sel = s;
        cmd_data = {a, b, c, 19'h7ffff};
        cmd_color = col;
    endtask

    initial begin
        step();
        step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", seg_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", shapes_done, 0);
        chk("rst_data", seg_data, 0);
        rst = 0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // line
        seg_ready = 1;
        cmd(0, pt(10, 20), pt(100, 200), pt(1, 1), 16'hf800);
        step();
        cmd_valid = 0;
        chk("line_valid", seg_valid, 1);
        chk("line_data", seg_data, {pt(10, 20), pt(100, 200)});
        chk("line_last", seg_last, 1);
        chk("line_kind", seg_kind, 0);
        chk("line_color", seg_color, 16'hf800);
        chk("line_busy", busy, 1);
        chk("line_ready", cmd_ready, 0);
        step();
        chk("line_end_valid", seg_valid, 0);
        chk("line_done", shapes_done, 1);
        chk("line_end_ready", cmd_ready, 1);

        // square, 3 stall cycles per segment
        sq[0] = {pt(5, 5), pt(50, 5)};
        sq[1] = {pt(50, 5), pt(50, 40)};
        sq[2] = {pt(50, 40), pt(5, 40)};
        sq[3] = {pt(5, 40), pt(5, 5)};
        seg_ready = 0;
        cmd(3, pt(5, 5), pt(50, 40), pt(0, 0), 16'h07e0);
        step();
        cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sq%0d_valid", i), seg_valid, 1);
                chk($sformatf("sq%0d_data", i), seg_data, sq[i]);
                chk($sformatf("sq%0d_last", i), seg_last, i == 3);
                chk($sformatf("sq%0d_color", i), seg_color, 16'h07e0);
                seg_ready = (k == 3);
                step();
            end
            seg_ready = 0;
        end
        chk("sq_end_valid", seg_valid, 0);
        chk("sq_done", shapes_done, 2);

        // triangle with circle command held pending until idle
        seg_ready = 1;
        cmd(2, pt(0, 0), pt(639, 0), pt(320, 479), 16'h001f);
        step();
        cmd(1, pt(320, 240), pt(50, 0), pt(9, 9), 16'hffff);
        chk("tri1", seg_data, {pt(0, 0), pt(639, 0)});
        chk("tri1_last", seg_last, 0);
        step();
        chk("tri2", seg_data, {pt(639, 0), pt(320, 479)});
        step();
        chk("tri3", seg_data, {pt(320, 479), pt(0, 0)});
        chk("tri3_last", seg_last, 1);
        chk("tri_color", seg_color, 16'h001f);
        step();
        chk("tri_gap_valid", seg_valid, 0);
        chk("tri_gap_ready", cmd_ready, 1);
        chk("tri_done", shapes_done, 3);
        step();
        cmd_valid = 0;
        chk("circ_valid", seg_valid, 1);
        chk("circ_data", seg_data, {pt(320, 240), pt(50, 0)});
        chk("circ_kind", seg_kind, 1);
        chk("circ_last", seg_last, 1);
        chk("circ_color", seg_color, 16'hffff);
        step();
        chk("circ_done", shapes_done, 4);
        chk("circ_end_valid", seg_valid, 0);

        // unsupported selector
        cmd(7, pt(1, 2), pt(3, 4), pt(5, 6), 16'h1234);
        step();
        cmd_valid = 0;
        chk("bad_err", err, 1);
        chk("bad_valid", seg_valid, 0);
        chk("bad_busy", busy, 0);
        step();
        chk("bad_err_drop", err, 0);
        chk("bad_valid2", seg_valid, 0);
        chk("bad_done", shapes_done, 4);

        // reset during SQ2 while stalled
        cmd(3, pt(1, 1), pt(9, 7), pt(0, 0), 16'h5555);
        step();
        cmd_valid = 0;
        chk("rsq1", seg_data, {pt(1, 1), pt(9, 1)});
        step();
        seg_ready = 0;
        chk("rsq2", seg_data, {pt(9, 1), pt(9, 7)});
        step();
        chk("rsq2_hold", seg_data, {pt(9, 1), pt(9, 7)});
        rst = 1;
        step();
        chk("mid_rst_valid", seg_valid, 0);
        chk("mid_rst_done", shapes_done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        rst = 0;
        seg_ready = 1;
        cmd(0, pt(7, 8), pt(9, 10), pt(0, 0), 16'h00aa);
        step();
        cmd_valid = 0;
        chk("post_line", seg_data, {pt(7, 8), pt(9, 10)});
        chk("post_line_last", seg_last, 1);
        step();
        chk("post_done", shapes_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
